// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_result;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_is_rem;

    logic            w_signed;
    logic            w_is_rem;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_fin;

    assign w_signed   = ~div_op[0];
    assign w_is_rem   = div_op[1];
    assign w_a_neg    = w_signed & op_a[XLEN-1];
    assign w_b_neg    = w_signed & op_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_abs_b    = w_b_neg ? (~op_b + 1'b1) : op_b;
    assign w_div_zero = (op_b == '0);
    assign w_ovf      = w_signed & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);

    // Overflow case: quotient is op_a itself (most negative value), remainder 0
    assign w_spec_res = w_div_zero ? (w_is_rem ? op_a : '1)
                                   : (w_is_rem ? '0 : op_a);

    // Remainder stays below the divisor, so the XLEN+1 bit difference sign is the borrow
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_ge     = ~w_diff[XLEN];
    assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

    assign w_fin = r_is_rem ? (r_r_neg ? (~w_rem_nx + 1'b1) : w_rem_nx)
                            : (r_q_neg ? (~w_quo_nx + 1'b1) : w_quo_nx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (kill) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q_neg  <= w_a_neg ^ w_b_neg;
                        r_r_neg  <= w_a_neg;
                        r_is_rem <= w_is_rem;
                        r_div    <= w_abs_b;
                        r_quo    <= w_abs_a;
                        r_rem    <= '0;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_spec_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= CW'(XLEN - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result <= w_fin;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_req = ~kill & (((r_state == S_IDLE) & start) | (r_state == S_CALC));
    assign busy      = (r_state == S_CALC);
    assign done      = (r_state == S_DONE) & ~kill;
    assign result    = r_result;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - vector table, random ops and kill/reset/ignored-start sequences for div_unit
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, kill;
    logic [1:0]  div_op;
    logic [31:0] op_a, op_b;
    logic        stall_req, busy, done;
    logic [31:0] result;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .div_op(div_op),
        .op_a(op_a), .op_b(op_b), .kill(kill),
        .stall_req(stall_req), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq;
        logic [31:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            2'b00: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin sq = sa / sb; r = sq; end
            end
            2'b01: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else r = a / b;
            end
            2'b10: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else begin sq = sa % sb; r = sq; end
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drives start in cycle 0 (next negedge) and follows the op to its done pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit poke);
        bit          seen = 0;
        bit          prof_ok = 1;
        int          got_lat = -1;
        logic [31:0] exp_r;
        @(negedge clk);
        start = 1'b1; div_op = op; op_a = a; op_b = b;
        exp_q.push_back(exp);
        #1 chk("stall_cycle0", {31'd0, stall_req}, 32'd1);
        for (int k = 1; k <= 80 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen    = 1;
                got_lat = k;
                exp_r   = exp_q.pop_front();
                chk("result", result, exp_r);
                last_res = exp_r;
                if (stall_req !== 1'b0 || busy !== 1'b0) prof_ok = 0;
            end else if (stall_req !== 1'b1 || busy !== 1'b1) begin
                prof_ok = 0;
            end
            start = 1'b0;
            if (poke && k >= 3 && k <= 6) begin
                start = 1'b1; div_op = 2'b01; op_a = 32'd50; op_b = 32'd5;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done expected done at cycle %0d", lat);
            void'(exp_q.pop_front());
        end else begin
            chk("latency", 32'(got_lat), 32'(lat));
        end
        chk("stall_busy_profile", {31'd0, prof_ok}, 32'd1);
    endtask

    task automatic idle_no_done(input string name, input int cycles);
        bit saw = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk(name, {31'd0, saw}, 32'd0);
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; div_op = 2'b00; op_a = '0; op_b = '0;
        last_res = '0;
        vecs = '{
            '{2'b01, 32'd100,        32'd7,        32'd14,        33},
            '{2'b11, 32'd100,        32'd7,        32'd2,         33},
            '{2'b00, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 33},
            '{2'b10, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE, 33},
            '{2'b10, 32'd100,        32'hFFFF_FFF9, 32'd2,        33},
            '{2'b00, 32'd5,          32'd0,        32'hFFFF_FFFF, 1},
            '{2'b11, 32'd5,          32'd0,        32'd5,         1},
            '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        1},
            '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        33},
            '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33},
            '{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,        33},
            '{2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 33},
            '{2'b01, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 33}
        };

        @(negedge clk);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_done",  {31'd0, done},      32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;

        // Table vectors run back-to-back: each start lands in the cycle after the previous done.
        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run_op(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), 1'b0);
        end

        // Kill in cycle 10 of a DIVU 1000/3, then a fresh op in cycle 12.
        @(negedge clk);
        start = 1'b1; div_op = 2'b01; op_a = 32'd1000; op_b = 32'd3;
        saw = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) saw = 1;
            start = 1'b0;
        end
        kill = 1'b1;
        #1 chk("kill_stall_drop", {31'd0, stall_req}, 32'd0);
        chk("kill_done_mask", {31'd0, done}, 32'd0);
        @(negedge clk);
        if (done) saw = 1;
        kill = 1'b0;
        chk("kill_busy_idle", {31'd0, busy}, 32'd0);
        chk("kill_no_done", {31'd0, saw}, 32'd0);
        chk("kill_result_held", result, last_res);
        run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b0);

        // Start pulses during CALC must not change the op or be queued.
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        idle_no_done("ignored_start_not_queued", 40);

        // Reset in cycle 5 of an op.
        @(negedge clk);
        start = 1'b1; div_op = 2'b01; op_a = 32'd1000; op_b = 32'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1 chk("midrst_stall", {31'd0, stall_req}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_no_done("midrst_no_done", 40);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
        run_op(2'b01, 32'd1000, 32'd3, 32'd333, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
